// File: rtl/regfile_sb.sv
// regfile_sb: register file for the pipelined core with a per-register busy scoreboard.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data  single synchronous write port (RUN only)
//   rd_addr/rd_data     NRD packed combinational read ports with write-to-read bypass
//   rd_busy             registered busy bit of each addressed register
//   sb_set/sb_addr      mark a register pending (destination of an issued instruction)
//   init_done           high once the post-reset clear sweep has finished
//   dbg_addr/dbg_data   debug read port, no bypass (REGFILE_DEBUG_EN only)
//   led                 high when stored x11 == 1 (REGFILE_DEBUG_EN only)
//
// Build option: define REGFILE_DEBUG_EN to build the debug port and led; otherwise they are
// tied to 0 and dbg_addr is ignored.
//
// The array has no reset. After rst_n deasserts an INIT sweep writes 0 to every entry,
// one per clock, and then the block sits in RUN until the next reset.

module regfile_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr,
  output logic                init_done,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data,
  output logic                led
);

  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [XLEN-1:0] mem [NREGS];

  // An address names a real, writable register: in range and not the hardwired zero.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic run;
  assign run       = (state_q == StRun);
  assign init_done = run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (state_q == StInit) begin
      if (cnt_q == AW'(NREGS - 1)) begin
        state_d = StRun;
      end else begin
        cnt_d = cnt_q + AW'(1);
      end
    end else begin
      // Clear first so a same-address issue (newer producer) leaves the bit set.
      if (wr_en && addr_ok(wr_addr)) busy_d[wr_addr] = 1'b0;
      if (sb_set && addr_ok(sb_addr)) busy_d[sb_addr] = 1'b1;
    end
  end

  // Array: sweep writes zeros during INIT, normal writes in RUN; no reset on purpose.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      mem[cnt_q] <= '0;
    end else if (wr_en && addr_ok(wr_addr)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < int'(NRD); k++) begin
      logic [AW-1:0] ra;
      ra = rd_addr[k*AW +: AW];
      if (run && addr_ok(ra)) begin
        // Busy is the registered value; a same-cycle write is covered by the bypass.
        rd_busy[k] = busy_q[ra];
        if (wr_en && (wr_addr == ra)) begin
          rd_data[k*XLEN +: XLEN] = wr_data;
        end else begin
          rd_data[k*XLEN +: XLEN] = mem[ra];
        end
      end
    end
  end

`ifdef REGFILE_DEBUG_EN
  always_comb begin
    dbg_data = '0;
    if (run && addr_ok(dbg_addr)) dbg_data = mem[dbg_addr];
  end

  if (NREGS > 11) begin : g_led
    assign led = run && (mem[11] == XLEN'(1));
  end else begin : g_no_led
    assign led = 1'b0;
  end
`else
  logic unused_dbg_addr;
  assign unused_dbg_addr = ^dbg_addr;
  assign dbg_data        = '0;
  assign led             = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb with default parameters.
// The stimulus process drives one cycle of inputs, computes the expected outputs from a
// behavioural model and queues them; the monitor pops and compares on each falling edge.

module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                wr_en = 1'b0;
  logic [AW-1:0]       wr_addr = '0;
  logic [XLEN-1:0]     wr_data = '0;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                sb_set = 1'b0;
  logic [AW-1:0]       sb_addr = '0;
  logic                init_done;
  logic [AW-1:0]       dbg_addr = '0;
  logic [XLEN-1:0]     dbg_data;
  logic                led;

  regfile_sb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .sb_set    (sb_set),
    .sb_addr   (sb_addr),
    .init_done (init_done),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .led       (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [63:0]     rd_data;
    logic [1:0]      rd_busy;
    logic            init_done;
    logic            led;
    logic [31:0]     dbg_data;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model: architectural registers, pending flags, and edges since reset release.
  logic [31:0] m_reg [NREGS];
  bit          m_busy [NREGS];
  int          m_edges = 0;

  function automatic bit ok(int a);
    return (a != 0) && (a < NREGS);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_reg[i]  = 32'h0;
      m_busy[i] = 1'b0;
    end
    m_edges = 0;
  endfunction

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endfunction

  task automatic step(string name, logic r, logic we, int wa, logic [31:0] wd,
                      int ra0, int ra1, logic sb, int sa, int da);
    exp_t e;
    bit   ready;
    int   ra [2];
    rst_n    = r;
    wr_en    = we;
    wr_addr  = wa[AW-1:0];
    wr_data  = wd;
    rd_addr  = {ra1[AW-1:0], ra0[AW-1:0]};
    sb_set   = sb;
    sb_addr  = sa[AW-1:0];
    dbg_addr = da[AW-1:0];
    if (!r) model_reset();
    ready = r && (m_edges >= NREGS);
    ra[0] = ra0;
    ra[1] = ra1;
    e.name      = name;
    e.rd_data   = '0;
    e.rd_busy   = '0;
    e.init_done = ready;
    for (int k = 0; k < 2; k++) begin
      logic [31:0] v;
      v = 32'h0;
      if (ready && ok(ra[k])) begin
        v = (we && wa == ra[k]) ? wd : m_reg[ra[k]];
        e.rd_busy[k] = m_busy[ra[k]];
      end
      e.rd_data[k*32 +: 32] = v;
    end
`ifdef REGFILE_DEBUG_EN
    e.led      = ready && (m_reg[11] == 32'd1);
    e.dbg_data = (ready && ok(da)) ? m_reg[da] : 32'h0;
`else
    e.led      = 1'b0;
    e.dbg_data = 32'h0;
`endif
    q.push_back(e);
    if (ready) begin
      if (we && ok(wa)) begin
        m_reg[wa]  = wd;
        m_busy[wa] = 1'b0;
      end
      if (sb && ok(sa)) m_busy[sa] = 1'b1;
    end
    @(posedge clk);
    #1;
    if (rst_n && m_edges < NREGS) m_edges++;
  endtask

  task automatic rd(string name, int ra0, int ra1, int da);
    step(name, 1'b1, 1'b0, 0, 32'h0, ra0, ra1, 1'b0, 0, da);
  endtask

  exp_t me;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      chk({me.name, "/rd_data0"}, 64'(rd_data[31:0]), 64'(me.rd_data[31:0]));
      chk({me.name, "/rd_data1"}, 64'(rd_data[63:32]), 64'(me.rd_data[63:32]));
      chk({me.name, "/rd_busy"}, 64'(rd_busy), 64'(me.rd_busy));
      chk({me.name, "/init_done"}, 64'(init_done), 64'(me.init_done));
      chk({me.name, "/led"}, 64'(led), 64'(me.led));
      chk({me.name, "/dbg_data"}, 64'(dbg_data), 64'(me.dbg_data));
    end
  end

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    step("in_reset", 1'b0, 1'b1, 4, 32'hFFFF_FFFF, 4, 5, 1'b1, 4, 4);
    step("in_reset", 1'b0, 1'b0, 0, 32'h0, 0, 0, 1'b0, 0, 0);
    // Sweep: writes and issues here must be dropped.
    for (int i = 0; i < NREGS; i++) begin
      step("init_sweep", 1'b1, 1'b1, 4, 32'hFFFF_FFFF, 4, i, 1'b1, 4, 4);
    end
    rd("after_init_x4", 4, 4, 4);

    step("wr_x5", 1'b1, 1'b1, 5, 32'hDEAD_BEEF, 1, 2, 1'b0, 0, 0);
    rd("rd_x5", 5, 5, 5);
    step("wr_x0", 1'b1, 1'b1, 0, 32'h0000_1234, 0, 0, 1'b0, 0, 0);
    rd("rd_x0", 0, 0, 0);

    step("wr_x6", 1'b1, 1'b1, 6, 32'h0000_0066, 6, 7, 1'b0, 0, 6);
    step("bypass_x7", 1'b1, 1'b1, 7, 32'hA5A5_A5A5, 7, 6, 1'b0, 0, 7);
    rd("rd_x7", 7, 6, 7);

    step("sb_x9", 1'b1, 1'b0, 0, 32'h0, 9, 9, 1'b1, 9, 0);
    rd("busy_x9", 9, 8, 0);
    step("wr_x9_clear", 1'b1, 1'b1, 9, 32'h0000_0099, 9, 9, 1'b0, 0, 0);
    rd("cleared_x9", 9, 9, 9);
    step("sb_wr_x9", 1'b1, 1'b1, 9, 32'h0000_0999, 9, 9, 1'b1, 9, 0);
    rd("set_wins_x9", 9, 9, 9);
    step("sb_x0", 1'b1, 1'b0, 0, 32'h0, 0, 0, 1'b1, 0, 0);
    rd("never_busy_x0", 0, 9, 0);
    step("sb_wr_diff", 1'b1, 1'b1, 9, 32'h1, 9, 10, 1'b1, 10, 0);
    rd("diff_addr", 9, 10, 9);

    step("wr_x11_1", 1'b1, 1'b1, 11, 32'h1, 11, 0, 1'b0, 0, 11);
    rd("led_on", 11, 0, 11);
    step("wr_x11_2", 1'b1, 1'b1, 11, 32'h2, 11, 0, 1'b0, 0, 11);
    rd("led_off_dbg", 11, 0, 11);

    step("wr_x3", 1'b1, 1'b1, 3, 32'h0000_0055, 3, 0, 1'b1, 3, 3);
    rd("rd_x3", 3, 3, 3);
    step("midrun_reset", 1'b0, 1'b0, 0, 32'h0, 3, 3, 1'b0, 0, 3);
    for (int i = 0; i < NREGS; i++) rd("reinit", 3, 11, 3);
    rd("x3_cleared", 3, 11, 3);

    for (int i = 0; i < 600; i++) begin
      step("random", ($urandom_range(0, 249) != 0), 1'(($urandom_range(0, 2) != 0)),
           int'($urandom_range(0, NREGS - 1)), $urandom(),
           int'($urandom_range(0, NREGS - 1)), int'($urandom_range(0, NREGS - 1)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, NREGS - 1)),
           int'($urandom_range(0, NREGS - 1)));
    end

    @(negedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
